holding_register_bank: RTL

- Parametrised bank of NREG holding registers, each WIDTH bits, clocked successor of the 1-bit holding element used in the transfer path.
- Each register either keeps its value or takes a new value: S-bus load, clear or increment, selected per register by a one-hot/multi-hot select vector.
- Two combinational read ports drive the A-bus and B-bus.
- A registered carry flag reports increment wrap-around; used for register file and PC/counter storage in the datapath.

---
 rtl/holding_register_bank.sv | 109 ++++++++++
 1 files changed

// File: rtl/holding_register_bank.sv
// holding_register_bank
// Bank of NREG holding registers of WIDTH bits. Every selected register takes
// the same operation each cycle (hold, S-bus load, clear or increment). Two
// combinational read ports drive the A-bus and B-bus, and a registered carry
// flag marks the cycle after any selected register wrapped on increment.
module holding_register_bank #(
   parameter int               WIDTH     = 16,
   parameter int               NREG      = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int               IDXW      = $clog2(NREG)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [WIDTH-1:0]        sbus,
   input  logic [NREG-1:0]         sr_sel,
   input  logic [1:0]              op,
   input  logic [IDXW-1:0]         ra_idx,
   input  logic [IDXW-1:0]         rb_idx,
   output logic [WIDTH-1:0]        abus,
   output logic [WIDTH-1:0]        bbus,
   output logic [NREG*WIDTH-1:0]   q_all,
   output logic                    carry_o
);

   // Operation encoding shared by every register in the bank.
   localparam logic [1:0] OP_HOLD  = 2'b00;
   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_CLEAR = 2'b10;
   localparam logic [1:0] OP_INC   = 2'b11;

   // Per-register "selected and currently all-ones": feeds the carry flag.
   logic [NREG-1:0] wrap_hit;

   // One-hot decode of each read index; an out-of-range index decodes to
   // nothing, which makes the bus read as zero.
   logic [NREG-1:0] ra_hit;
   logic [NREG-1:0] rb_hit;

   logic carry_q;
   logic carry_d;

   genvar gi;
   generate
      for (gi = 0; gi < NREG; gi++) begin : g_reg
         logic [WIDTH-1:0] val_q;
         logic [WIDTH-1:0] val_d;

         // Next value of this register. sbus is only looked at when this
         // register is selected for LOAD, so an undriven S-bus never leaks
         // into registers that are not being written.
         always_comb begin
            val_d = val_q;
            if (sr_sel[gi]) begin
               case (op)
                  OP_HOLD:  val_d = val_q;
                  OP_LOAD:  val_d = sbus;
                  OP_CLEAR: val_d = '0;
                  OP_INC:   val_d = val_q + WIDTH'(1);
                  default:  val_d = val_q;
               endcase
            end
         end

         // Register storage; reset forces RESET_VAL at once, dropping any
         // operation that was being presented.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               val_q <= RESET_VAL;
            end else begin
               val_q <= val_d;
            end
         end

         assign q_all[gi*WIDTH +: WIDTH] = val_q;
         assign wrap_hit[gi]             = sr_sel[gi] & (&val_q);
         assign ra_hit[gi]               = (ra_idx == IDXW'(gi));
         assign rb_hit[gi]               = (rb_idx == IDXW'(gi));
      end
   endgenerate

   // Read ports: AND-OR mux over the decoded index, no read latency and no
   // bypass of a write presented in the same cycle.
   always_comb begin
      abus = '0;
      bbus = '0;
      for (int i = 0; i < NREG; i++) begin
         abus = abus | (q_all[i*WIDTH +: WIDTH] & {WIDTH{ra_hit[i]}});
         bbus = bbus | (q_all[i*WIDTH +: WIDTH] & {WIDTH{rb_hit[i]}});
      end
   end

   // Carry is recomputed every cycle, so it is high only for the cycle
   // directly after a wrapping increment.
   always_comb begin
      carry_d = (op == OP_INC) && (|wrap_hit);
   end

   // Carry flag storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         carry_q <= 1'b0;
      end else begin
         carry_q <= carry_d;
      end
   end

   assign carry_o = carry_q;

endmodule
